// File: rtl/mux_arb_reg.sv
// Registered N-input multiplexer with per-channel valid/ready handshake.
// Selection is either external (mode 0, via sel) or round-robin (mode 1).
// A one-entry output register gives one-cycle latency and allows a drain
// and a new load in the same cycle, so full throughput is kept.
module mux_arb_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SELW   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SELW-1:0]         sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SELW-1:0]         out_src,
  input  logic                    out_ready
);

  localparam int unsigned N  = NUM_IN;
  localparam int          IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [SELW-1:0]  last;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             can_load;
  logic             xfer;
  int unsigned      idx;

  // Slot can take new data when empty or being drained this cycle.
  assign can_load = !out_valid || out_ready;
  assign xfer     = grant_vld && can_load && !reset;

  // Grant selection: fixed index in mode 0, rotating search after last in mode 1.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (mode) begin
      // Search order wraps modulo NUM_IN, starting just after last.
      for (int unsigned k = 1; k <= N; k++) begin
        idx = (32'(last) + k) % N;
        if (!grant_vld && in_valid[idx[IW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(idx);
        end
      end
    end else begin
      // Only in-range channels are compared, so an out-of-range sel never grants.
      for (int unsigned i = 0; i < N; i++) begin
        if (SELW'(i) == sel && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end
  end

  // Route granted channel data and raise its ready when the slot can load.
  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_vld && SELW'(i) == grant_idx) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = can_load && !reset;
      end
    end
  end

  // Output register and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      last      <= SELW'(NUM_IN - 1);
    end else if (xfer) begin
      out_data  <= grant_data;
      out_src   <= grant_idx;
      out_valid <= 1'b1;
      if (mode) begin
        last <= grant_idx;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed self-checking bench for mux_arb_reg (WIDTH=32, NUM_IN=4, SELW=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mux_arb_reg;

  logic         clk;
  logic         reset;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic         mode;
  logic [1:0]   sel;
  logic [31:0]  out_data;
  logic         out_valid;
  logic [1:0]   out_src;
  logic         out_ready;

  int nvec = 0;
  int nerr = 0;

  mux_arb_reg #(.WIDTH(32), .NUM_IN(4), .SELW(2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_src(out_src), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; mode = 1'b1; sel = 2'd0;
    #1;
    nvec++; if (in_ready !== 4'b0000) begin nerr++; $display("FAIL reset_ready0 got %b exp 0000", in_ready); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      nvec++; if (out_data !== 32'h0) begin nerr++; $display("FAIL reset_data got %h exp 0", out_data); end
      nvec++; if (in_ready !== 4'b0000) begin nerr++; $display("FAIL reset_ready got %b exp 0000", in_ready); end
    end
    nvec++; if (out_src !== 2'd0) begin nerr++; $display("FAIL reset_src got %0d exp 0", out_src); end
    reset = 1'b0;
    #1;
    nvec++; if (in_ready !== 4'b0001) begin nerr++; $display("FAIL reset_first_grant got %b exp 0001", in_ready); end
    in_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_d;
    @(negedge clk);
    in_valid = 4'b1111; mode = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_d = 32'hA0 + 32'(k % 4);
      nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL rr_valid[%0d] got %b exp 1", k, out_valid); end
      nvec++; if (out_data !== exp_d) begin nerr++; $display("FAIL rr_data[%0d] got %h exp %h", k, out_data, exp_d); end
      nvec++; if (out_src !== 2'(k % 4)) begin nerr++; $display("FAIL rr_src[%0d] got %0d exp %0d", k, out_src, k % 4); end
    end
    in_valid = 4'b0000;
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rr_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_fixed_select();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    nvec++; if (in_ready !== 4'b0100) begin nerr++; $display("FAIL fix_ready got %b exp 0100", in_ready); end
    @(negedge clk);
    nvec++; if (out_data !== 32'hA2) begin nerr++; $display("FAIL fix_data got %h exp 000000a2", out_data); end
    nvec++; if (out_src !== 2'd2) begin nerr++; $display("FAIL fix_src got %0d exp 2", out_src); end
    sel = 2'd1;
    #1;
    nvec++; if (in_ready !== 4'b0000) begin nerr++; $display("FAIL fix_nogrant got %b exp 0000", in_ready); end
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL fix_drop got %b exp 0", out_valid); end
    nvec++; if (out_data !== 32'hA2) begin nerr++; $display("FAIL fix_hold got %h exp 000000a2", out_data); end
    in_valid = 4'b0000;
  endtask

  task automatic test_back_pressure();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
    @(negedge clk);
    nvec++; if (out_data !== 32'hA1) begin nerr++; $display("FAIL bp_load got %h exp 000000a1", out_data); end
    out_ready = 1'b0; in_valid = 4'b1111; sel = 2'd2;
    for (int c = 0; c < 3; c++) begin
      #1;
      nvec++; if (in_ready !== 4'b0000) begin nerr++; $display("FAIL bp_ready[%0d] got %b exp 0000", c, in_ready); end
      @(negedge clk);
      nvec++; if (out_data !== 32'hA1) begin nerr++; $display("FAIL bp_hold[%0d] got %h exp 000000a1", c, out_data); end
      nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid[%0d] got %b exp 1", c, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    nvec++; if (in_ready !== 4'b0100) begin nerr++; $display("FAIL bp_release got %b exp 0100", in_ready); end
    @(negedge clk);
    nvec++; if (out_data !== 32'hA2) begin nerr++; $display("FAIL bp_swap got %h exp 000000a2", out_data); end
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL bp_nobubble got %b exp 1", out_valid); end
    in_valid = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_sparse_rr();
    logic [31:0] exp_d;
    // Pointer is still 3 from the round-robin run; mode 0 must not have moved it.
    mode = 1'b1; in_valid = 4'b1000; out_ready = 1'b1;
    #1;
    nvec++; if (in_ready !== 4'b1000) begin nerr++; $display("FAIL sp_ready3 got %b exp 1000", in_ready); end
    @(negedge clk);
    nvec++; if (out_src !== 2'd3) begin nerr++; $display("FAIL sp_src3 got %0d exp 3", out_src); end
    in_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_d = (k % 2 == 0) ? 32'hA0 : 32'hA2;
      nvec++; if (out_data !== exp_d) begin nerr++; $display("FAIL sp_data[%0d] got %h exp %h", k, out_data, exp_d); end
    end
    in_valid = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stall();
    // Pointer is 2 here, so channel 3 is searched first.
    mode = 1'b1; in_valid = 4'b1000; out_ready = 1'b1;
    @(negedge clk);
    nvec++; if (out_data !== 32'hA3) begin nerr++; $display("FAIL rs_load got %h exp 000000a3", out_data); end
    out_ready = 1'b0; in_valid = 4'b1111;
    @(negedge clk);
    nvec++; if (out_data !== 32'hA3 || out_valid !== 1'b1) begin nerr++; $display("FAIL rs_stall got %h/%b exp 000000a3/1", out_data, out_valid); end
    reset = 1'b1;
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rs_valid got %b exp 0", out_valid); end
    nvec++; if (out_data !== 32'h0) begin nerr++; $display("FAIL rs_data got %h exp 0", out_data); end
    reset = 1'b0; out_ready = 1'b1;
    #1;
    nvec++; if (in_ready !== 4'b0001) begin nerr++; $display("FAIL rs_grant got %b exp 0001", in_ready); end
    @(negedge clk);
    nvec++; if (out_data !== 32'hA0 || out_src !== 2'd0) begin nerr++; $display("FAIL rs_next got %h/%0d exp 000000a0/0", out_data, out_src); end
    in_valid = 4'b0000;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + 32'(i);
    reset = 1'b1; in_valid = '0; out_ready = 1'b0; mode = 1'b0; sel = '0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_fixed_select();
    test_back_pressure();
    test_sparse_rr();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mux_arb_reg.md
# mux_arb_reg

Parametrised, registered N-input multiplexer with per-channel valid/ready handshake and two selection modes: externally selected, or round-robin arbitrated. It replaces the fixed 2:1/3:1 datapath multiplexers wherever several producers compete for one consumer, such as writeback sources or memory request ports. A one-entry output register gives a one-cycle latency and supports full throughput under back-pressure.

## Interface
- WIDTH, 32, data width in bits of each channel and of the output
- NUM_IN, 4, number of input channels; legal range 2..8
- SELW, 2, width of `sel` and `out_src`; requires NUM_IN <= 2**SELW
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_IN  bit i high means channel i presents data
- in_ready  output  NUM_IN  bit i high means channel i is accepted this cycle; at most one bit is high
- mode  input  1  0 = fixed select via `sel`; 1 = round-robin
- sel  input  SELW  channel index used when mode = 0
- out_data  output  WIDTH  registered data
- out_valid  output  1  output register holds valid data
- out_src  output  SELW  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- State:
  - output register: out_data, out_src, and a full flag (the full flag is out_valid)
  - round-robin pointer `last`, SELW bits
- can_load = !out_valid || out_ready. The slot is empty, or it is being drained this cycle.
- Grant, combinational:
  - mode 0: grant = sel if sel < NUM_IN && in_valid[sel]. Otherwise there is no grant. An out-of-range sel never grants.
  - mode 1: grant = first i with in_valid[i] set, searching (last+1) mod NUM_IN, (last+2) mod NUM_IN, … and wrapping. If no input is valid, there is no grant.
- in_ready[i] = can_load && (grant exists) && (i == grant). in_ready depends combinationally on out_ready and in_valid. It does not depend on itself.
- Load, on an input transfer (in_valid[g] && in_ready[g]):
  - out_data <= channel g data
  - out_src <= g
  - out_valid <= 1
  - in mode 1 only, last <= g
- Drain without load (out_valid && out_ready && no input transfer): out_valid <= 0. out_data and out_src hold their last values.
- Stall (out_valid && !out_ready): out_data, out_src and out_valid hold. All in_ready bits are 0.
- Simultaneous drain and load in the same cycle: the new data replaces the old, and out_valid stays 1. There is no bubble.
- The mode-0 path never changes `last`. Switching mode 0 to 1 resumes rotation from the stored `last`.
- A mode or sel change never alters data already in the register.
- Arithmetic: the pointer wraps modulo NUM_IN, not modulo 2**SELW. With NUM_IN = 3, the search order after last = 2 is 0, 1, 2.

## Timing
- Reset values:
  - out_valid = 0
  - out_data = 0
  - out_src = 0
  - last = NUM_IN-1, so channel 0 has first priority
  - in_ready = 0 while reset is high
- Reset mid-operation: held data is discarded and not presented. Inputs offered during the reset cycle are not accepted.
- Latency: data accepted at edge N is visible on out_data/out_valid after edge N, one cycle.
- Throughput: one transfer per cycle while out_ready = 1 and some grant exists.
- Fairness, mode 1 with all NUM_IN channels continuously valid and out_ready = 1: grants rotate 0, 1, …, NUM_IN-1, 0, … with no channel starved.
- Handshake rules:
  - An input transfer occurs only in a cycle where both in_valid[i] and in_ready[i] are high.
  - An output transfer occurs only in a cycle where both out_valid and out_ready are high.
  - Producers may drop in_valid without having been accepted.

## Test plan
Bench configuration: WIDTH = 32, NUM_IN = 4, SELW = 2.
- Reset: hold reset 2 cycles with all in_valid = 4'b1111 and out_ready = 1 -> out_valid = 0, out_data = 0, in_ready = 0 during reset. The first grant after release is channel 0.
- Round-robin: channel i data = 32'hA0+i, all in_valid = 1, out_ready = 1, mode = 1 for 8 cycles -> out_data sequence A0, A1, A2, A3, A0, A1, A2, A3, with out_src matching each value.
- Fixed select and out-of-range: mode = 0, sel = 2, in_valid = 4'b0100 -> out_data = A2 one cycle later. Then sel = 1 with in_valid[1] = 0 -> no grant, and out_valid drops after the drain.
- Back-pressure: load A1, then out_ready = 0 for 3 cycles with all inputs valid -> out_data holds A1, out_valid = 1, in_ready = 0. Raise out_ready -> A1 drains and A2 loads in the same cycle, with no bubble.
- Sparse round-robin: after a grant to channel 3, in_valid = 4'b0101 -> grant 0 then 2, alternating.
- Reset mid-stall: out_valid = 1 holding A3 with out_ready = 0, then pulse reset for 1 cycle -> out_valid = 0 and out_data = 0 next cycle. The next grant in mode 1 is channel 0.
